dp_ram_be: RTL and testbench
============================

Name: dp_ram_be

Overview:
- Parameterised dual-port synchronous RAM. Successor to the team's single-port RAM.
- Port A is read/write with per-byte write enables. Port B is read-only.
- Adds a selectable read-during-write mode, a configurable read latency of 1 or 2 cycles, and read-valid flags.
- A hardware clear engine zeroes the whole array after reset or on request.
- Used as a packet/descriptor buffer between a producer (port A) and a consumer (port B) on one clock.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 6: address width. DEPTH = 2**ADDR_WIDTH words.
- RD_LATENCY, 1: read latency in cycles. Legal values are 1 and 2. Any other value is a compile-time error.
- RDW_MODE, 0: read-during-write result on a same-address collision. 0 = read-first (old data). 1 = write-first (new data).
- BE_WIDTH, DATA_WIDTH/8: derived localparam; not for override.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-low reset.
- clr, in, 1: one-cycle request to zero the array.
- busy, out, 1: high while the clear engine runs.
- a_en, in, 1: port A access enable.
- a_we, in, BE_WIDTH: port A byte write enables. Bit i writes byte i. All zeros with a_en=1 is a read.
- a_addr, in, ADDR_WIDTH: port A address.
- a_din, in, DATA_WIDTH: port A write data.
- a_dout, out, DATA_WIDTH: port A read data.
- a_rvalid, out, 1: a_dout is valid this cycle.
- b_en, in, 1: port B read enable.
- b_addr, in, ADDR_WIDTH: port B address.
- b_dout, out, DATA_WIDTH: port B read data.
- b_rvalid, out, 1: b_dout is valid this cycle.

Behaviour:
- Reset (rst=0 at a rising edge):
  - a_dout, b_dout and all pipeline stages go to 0.
  - a_rvalid and b_rvalid go to 0.
  - Clear FSM goes to CLEAR with the clear counter at 0, so busy=1 on the first cycle after reset is released.
  - Reset asserted mid-clear restarts the clear from address 0.
- Clear FSM:
  - IDLE: busy=0. clr=1 moves to CLEAR with counter=0.
  - CLEAR: busy=1. Each cycle writes 0 to mem[counter], then counter increments.
  - When counter == DEPTH-1, that write completes and the FSM returns to IDLE.
  - A clear takes exactly DEPTH cycles. busy falls on the cycle after the last write.
  - clr while already in CLEAR is ignored and does not restart the count.
- While busy=1:
  - a_en and b_en are ignored; no user writes happen.
  - a_rvalid and b_rvalid stay 0.
  - a_dout and b_dout hold their last values.
  - An access issued in the cycle clr is sampled is also ignored.
- Port A:
  - With a_en=1, bytes selected by a_we are written at the clock edge; unselected bytes keep their contents.
  - A read is performed on every a_en=1 cycle, including writes.
  - On a write, a_dout follows RDW_MODE: mode 0 returns the pre-write word; mode 1 returns the merged post-write word.
- Port B:
  - b_en=1 reads mem[b_addr].
  - Collision (a_en=1, a_we!=0, a_addr==b_addr in the same cycle) follows RDW_MODE exactly as port A.
  - A partial-byte write in write-first mode returns the merged word.
- Latency:
  - RD_LATENCY=1: data and rvalid appear 1 cycle after the enable.
  - RD_LATENCY=2: data and rvalid appear 2 cycles after the enable, through an extra output register.
  - rvalid is the enable delayed through the same pipeline.
  - Throughput is one access per port per cycle, with no stalls outside CLEAR.
- When en=0, dout holds its last valid value; rvalid=0.
- Addresses are always in range (DEPTH is a power of 2). No wrap logic is needed beyond the clear counter.

Test Plan:
- Reset, then idle → busy=1 for exactly 64 cycles (ADDR_WIDTH=6), then 0. Reading any address afterwards returns 0x00000000 with b_rvalid=1 one cycle after b_en.
- Write 0xDEADBEEF to addr 5 with a_we=4'b1111, then a_we=4'b0010 with a_din=0x00001200 to addr 5 → port B read of addr 5 returns 0xDEAD12EF.
- Collision: mem[9]=0x11111111, then A writes 0x22222222 to addr 9 while B reads addr 9 → b_dout=0x11111111 (RDW_MODE=0) or 0x22222222 (RDW_MODE=1). a_dout matches b_dout in both cases.
- RD_LATENCY=2: back-to-back port B reads of addrs 1, 2, 3 holding 0xA, 0xB, 0xC → b_rvalid high on cycles 2, 3 and 4 after the first enable, with data 0xA, 0xB, 0xC.
- Pulse clr while addr 7 holds 0x55; drive a_en with a write during busy → the write has no effect and rvalid=0. After busy falls, addr 7 reads 0.
- Assert rst mid-clear at count 30 → busy is still 1 after release, and the clear runs a full 64 cycles from address 0.

Source files
------------

// File: rtl/dp_ram_be.sv
// dp_ram_be: dual-port synchronous RAM with byte enables and a clear engine.
//
// Port A reads and writes with per-byte write enables. Port B is read-only.
// Both ports share one clock. The read-during-write result is selectable, and
// the read latency can be 1 or 2 cycles. Each read comes with a valid flag.
// A clear engine zeroes every word after reset and whenever clr is pulsed.
//
// Ports:
//   clk       - single clock; all logic runs on the rising edge
//   rst       - synchronous reset, active low
//   clr       - one-cycle request to zero the whole array
//   busy      - high while the clear engine runs
//   a_en      - port A access enable (read, or write when a_we != 0)
//   a_we      - port A byte write enables; bit i writes byte i
//   a_addr    - port A address
//   a_din     - port A write data
//   a_dout    - port A read data
//   a_rvalid  - a_dout holds the result of an accepted port A access
//   b_en      - port B read enable
//   b_addr    - port B address
//   b_dout    - port B read data
//   b_rvalid  - b_dout holds the result of an accepted port B read
//
// Read handshake: an enable is accepted on a rising edge only when the clear
// engine is idle and clr is low. Exactly RD_LATENCY cycles later, rvalid is
// high for one cycle together with the data. Nothing can stall a port. dout
// keeps its last delivered value whenever rvalid is low.

module dp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_rvalid
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dp_ram_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("dp_ram_be: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    acc_ok;
    logic                    a_rd, a_wr, b_rd, collide;
    logic [DATA_WIDTH-1:0]   a_old, a_merged, b_old;
    logic [DATA_WIDTH-1:0]   a_rdata, b_rdata;

    logic [DATA_WIDTH-1:0]   a_d1_q, b_d1_q;
    logic                    a_v1_q, b_v1_q;

    // ---------------- clear engine ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // A clr pulse in this state is ignored, so a running count
                // is never restarted by a request.
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset starts a full clear from address 0. This also holds
            // when reset arrives in the middle of a clear.
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    // ---------------- access qualification and read data ----------------
    // An access in the same cycle that clr is sampled is dropped.
    assign acc_ok  = rst && !busy && !clr;
    assign a_rd    = a_en && acc_ok;
    assign a_wr    = a_rd && (|a_we);
    assign b_rd    = b_en && acc_ok;
    assign collide = a_wr && (a_addr == b_addr);

    assign a_old = mem_q[a_addr];
    assign b_old = mem_q[b_addr];

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (a_we[i]) begin
                a_merged[i*8 +: 8] = a_din[i*8 +: 8];
            end
        end
    end

    // In write-first mode, a read returns the merged word. This covers port A
    // on its own write and port B on a same-address collision. When no byte
    // is enabled, the merged word equals the stored word.
    assign a_rdata = (RDW_MODE == 1) ? a_merged : a_old;
    assign b_rdata = (RDW_MODE == 1 && collide) ? a_merged : b_old;

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (rst && busy) begin
            mem_q[cnt_q] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (a_we[i]) begin
                    mem_q[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- read pipeline, stage 1 ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_d1_q <= '0;
            b_d1_q <= '0;
            a_v1_q <= 1'b0;
            b_v1_q <= 1'b0;
        end else begin
            a_v1_q <= a_rd;
            b_v1_q <= b_rd;
            if (a_rd) a_d1_q <= a_rdata;
            if (b_rd) b_d1_q <= b_rdata;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] a_d2_q, b_d2_q;
        logic                  a_v2_q, b_v2_q;
        logic                  flush;

        // A read accepted just before a clr pulse would otherwise come out
        // while busy is high. It is dropped so that rvalid stays low and
        // dout holds during the clear.
        assign flush = (state_d == ST_CLEAR);

        always_ff @(posedge clk) begin
            if (!rst) begin
                a_d2_q <= '0;
                b_d2_q <= '0;
                a_v2_q <= 1'b0;
                b_v2_q <= 1'b0;
            end else begin
                a_v2_q <= a_v1_q && !flush;
                b_v2_q <= b_v1_q && !flush;
                if (a_v1_q && !flush) a_d2_q <= a_d1_q;
                if (b_v1_q && !flush) b_d2_q <= b_d1_q;
            end
        end

        assign a_dout   = a_d2_q;
        assign b_dout   = b_d2_q;
        assign a_rvalid = a_v2_q;
        assign b_rvalid = b_v2_q;
    end else begin : g_lat1
        assign a_dout   = a_d1_q;
        assign b_dout   = b_d1_q;
        assign a_rvalid = a_v1_q;
        assign b_rvalid = b_v1_q;
    end

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be. Two instances share the same stimulus:
//   dut0: RD_LATENCY=1, RDW_MODE=0 (read-first)
//   dut1: RD_LATENCY=2, RDW_MODE=1 (write-first)
// Scoreboard stream index p: 0 = dut0 port A, 1 = dut0 port B,
//                            2 = dut1 port A, 3 = dut1 port B.

module tb_dp_ram_be;

  localparam int W  = 32;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          a_en = 1'b0;
  logic [3:0]    a_we = '0;
  logic [AW-1:0] a_addr = '0;
  logic [W-1:0]  a_din = '0;
  logic          b_en = 1'b0;
  logic [AW-1:0] b_addr = '0;

  logic          busy0, busy1;
  logic [W-1:0]  a0_dout, b0_dout, a1_dout, b1_dout;
  logic          a0_rv, b0_rv, a1_rv, b1_rv;

  dp_ram_be #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a0_dout), .a_rvalid(a0_rv),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b0_dout), .b_rvalid(b0_rv)
  );

  dp_ram_be #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a1_dout), .a_rvalid(a1_rv),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b1_dout), .b_rvalid(b1_rv)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Each entry is {issue cycle[15:0], expected data}.
  logic [47:0]  exp_q[4][$];
  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] last_val [4];
  logic [3:0]   rv;
  logic [W-1:0] dq [4];

  assign rv = {b1_rv, a1_rv, b0_rv, a0_rv};
  assign dq[0] = a0_dout;
  assign dq[1] = b0_dout;
  assign dq[2] = a1_dout;
  assign dq[3] = b1_dout;

  function automatic string stream_name(input int p);
    return $sformatf("dut%0d_%s", p / 2, (p % 2) ? "b" : "a");
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) last_val[p] = '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (rv[p]) begin
          if (exp_q[p].size() == 0) begin
            check_val({stream_name(p), "_spurious_rvalid"}, 32'(rv[p]), 32'd0);
          end else begin
            logic [47:0] e;
            e = exp_q[p].pop_front();
            check_val({stream_name(p), "_data"}, dq[p], e[31:0]);
            check_val({stream_name(p), "_latency"}, 32'(cyc - int'(e[47:32])),
                      (p < 2) ? 32'd1 : 32'd2);
            last_val[p] = e[31:0];
          end
        end else begin
          check_val({stream_name(p), "_hold"}, dq[p], last_val[p]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic cl, input logic ae, input logic [3:0] we,
                       input logic [AW-1:0] aa, input logic [W-1:0] ad,
                       input logic be, input logic [AW-1:0] ba);
    logic [W-1:0] old_a, merged, old_b;
    logic         coll;
    clr = cl; a_en = ae; a_we = we; a_addr = aa; a_din = ad;
    b_en = be; b_addr = ba;
    if (!cl) begin
      old_a = model_mem[aa];
      old_b = model_mem[ba];
      for (int i = 0; i < 4; i++) merged[i*8 +: 8] = we[i] ? ad[i*8 +: 8] : old_a[i*8 +: 8];
      coll = ae && (we != 4'd0) && (aa == ba);
      if (ae) begin
        exp_q[0].push_back({16'(cyc), old_a});
        exp_q[2].push_back({16'(cyc), merged});
      end
      if (be) begin
        exp_q[1].push_back({16'(cyc), old_b});
        exp_q[3].push_back({16'(cyc), coll ? merged : old_b});
      end
      if (ae && we != 4'd0) model_mem[aa] = merged;
    end
    @(posedge clk); #1;
    clr = 1'b0; a_en = 1'b0; a_we = '0; b_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0; clr = 1'b0; a_en = 1'b0; b_en = 1'b0; a_we = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Counts busy cycles of both instances until the clear finishes. When poke
  // is set, a write and a read of address 7 are driven during every busy
  // cycle. These accesses must have no effect.
  task automatic wait_clear(input bit poke);
    int  n0 = 0, n1 = 0, guard = 0;
    bit  done = 1'b0;
    while (!done && guard < 300) begin
      @(negedge clk);
      guard++;
      if (busy0) n0++;
      if (busy1) n1++;
      if (!busy0 && !busy1) done = 1'b1;
      else if (poke) begin
        a_en = 1'b1; a_we = 4'hF; a_addr = 6'd7; a_din = $urandom;
        b_en = 1'b1; b_addr = 6'd7;
      end
    end
    a_en = 1'b0; b_en = 1'b0; a_we = '0;
    check_val("clear_done", 32'(done), 32'd1);
    check_val("busy_len_dut0", n0, DEPTH);
    check_val("busy_len_dut1", n1, DEPTH);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset, then the clear engine runs for exactly DEPTH cycles.
    apply_reset(3);
    wait_clear(1'b0);

    // Every word reads back as zero after the clear.
    drive(1'b0, 1'b1, 4'h0, 6'd0,  '0, 1'b1, 6'd17);
    drive(1'b0, 1'b1, 4'h0, 6'd63, '0, 1'b1, 6'd0);
    drive(1'b0, 1'b0, 4'h0, 6'd0,  '0, 1'b1, 6'd63);
    idle(3);

    // Byte-enable merge: expect 0xDEAD12EF at address 5.
    drive(1'b0, 1'b1, 4'hF, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 4'b0010, 6'd5, 32'h00001200, 1'b0, 6'd0);
    drive(1'b0, 1'b0, 4'h0, 6'd0, '0, 1'b1, 6'd5);
    idle(3);
    check_val("merge_model_addr5", model_mem[5], 32'hDEAD12EF);

    // Same-address collision between the port A write and the port B read.
    drive(1'b0, 1'b1, 4'hF, 6'd9, 32'h11111111, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 4'hF, 6'd9, 32'h22222222, 1'b1, 6'd9);
    idle(3);

    // Collision where only some bytes are written.
    drive(1'b0, 1'b1, 4'b1001, 6'd9, 32'hAB0000CD, 1'b1, 6'd9);
    idle(3);

    // Back-to-back reads of addresses 1, 2 and 3 on both ports.
    drive(1'b0, 1'b1, 4'hF, 6'd1, 32'h0000000A, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 4'hF, 6'd2, 32'h0000000B, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 4'hF, 6'd3, 32'h0000000C, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 4'h0, 6'd3, '0, 1'b1, 6'd1);
    drive(1'b0, 1'b1, 4'h0, 6'd2, '0, 1'b1, 6'd2);
    drive(1'b0, 1'b1, 4'h0, 6'd1, '0, 1'b1, 6'd3);
    idle(3);

    // Random traffic on a narrow address window, so collisions are frequent.
    for (int k = 0; k < 200; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            6'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)));
    end
    idle(3);

    // A clr pulse with a write in the same cycle, then writes during busy.
    drive(1'b0, 1'b1, 4'hF, 6'd7, 32'h00000055, 1'b0, 6'd0);
    idle(3);
    drive(1'b1, 1'b1, 4'hF, 6'd7, 32'h000000AA, 1'b1, 6'd7);
    wait_clear(1'b1);
    drive(1'b0, 1'b1, 4'h0, 6'd7, '0, 1'b1, 6'd7);
    idle(3);

    // Fill the array, start a clear, and assert reset when the count is 30.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 4'hF, 6'(i), 32'hC0DE0000 | 32'(i + 1), 1'b0, 6'd0);
    end
    idle(3);
    drive(1'b1, 1'b0, 4'h0, 6'd0, '0, 1'b0, 6'd0);
    repeat (30) @(posedge clk);
    #1;
    check_val("busy_mid_clear", 32'(busy0 & busy1), 32'd1);
    apply_reset(2);
    check_val("busy_after_release", 32'(busy0 & busy1), 32'd1);
    wait_clear(1'b0);
    drive(1'b0, 1'b1, 4'h0, 6'd0,  '0, 1'b1, 6'd29);
    drive(1'b0, 1'b1, 4'h0, 6'd30, '0, 1'b1, 6'd31);
    drive(1'b0, 1'b1, 4'h0, 6'd62, '0, 1'b1, 6'd63);
    idle(5);

    for (int p = 0; p < 4; p++) begin
      check_val({stream_name(p), "_queue_empty"}, exp_q[p].size(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
